// File: rtl/sd_mirror_buf.sv
// Buffered, destination-masked mirror: each accepted word is delivered once to every
// receiver in its mask. Receivers handshake independently, and every output comes from a flop.
module sd_mirror_buf #(
  parameter int mirror_cnt = 2,
  parameter int width      = 32,
  parameter int depth      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_srdy,
  output logic                  c_drdy,
  input  logic [width-1:0]      c_data,
  input  logic [mirror_cnt-1:0] c_dst_vld,
  output logic [mirror_cnt-1:0] p_srdy,
  input  logic [mirror_cnt-1:0] p_drdy,
  output logic [width-1:0]      p_data
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [width-1:0]      data_q [depth];
  logic [width-1:0]      data_d [depth];
  logic [mirror_cnt-1:0] pend_q [depth];
  logic [mirror_cnt-1:0] pend_d [depth];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  c_drdy_q, c_drdy_d;
  logic [mirror_cnt-1:0] p_srdy_q, p_srdy_d;
  logic [width-1:0]      p_data_q, p_data_d;

  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [mirror_cnt-1:0] xfer_s;
  logic [mirror_cnt-1:0] head_left_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Next FIFO state, then the registered view of the head it will expose.
  always_comb begin
    data_d      = data_q;
    pend_d      = pend_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    empty_s     = (count_q == {CW{1'b0}});
    xfer_s      = p_srdy_q & p_drdy;
    head_left_s = pend_q[rd_ptr_q] & ~xfer_s;
    push_s      = c_srdy & c_drdy_q;
    pop_s       = ~empty_s & (head_left_s == {mirror_cnt{1'b0}});

    // Delivered receivers drop out of the head so they are never offered it again.
    if (!empty_s) begin
      pend_d[rd_ptr_q] = head_left_s;
    end else begin
      pend_d[rd_ptr_q] = pend_q[rd_ptr_q];
    end

    if (push_s) begin
      data_d[wr_ptr_q] = c_data;
      pend_d[wr_ptr_q] = (c_dst_vld == {mirror_cnt{1'b0}}) ? {mirror_cnt{1'b1}} : c_dst_vld;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    c_drdy_d = (count_d != FULL_CNT);
    p_data_d = data_d[rd_ptr_d];
    if (count_d != {CW{1'b0}}) begin
      p_srdy_d = pend_d[rd_ptr_d];
    end else begin
      p_srdy_d = {mirror_cnt{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        data_q[i] <= {width{1'b0}};
        pend_q[i] <= {mirror_cnt{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      c_drdy_q <= 1'b1;
      p_srdy_q <= {mirror_cnt{1'b0}};
      p_data_q <= {width{1'b0}};
    end else begin
      for (int i = 0; i < depth; i++) begin
        data_q[i] <= data_d[i];
        pend_q[i] <= pend_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      c_drdy_q <= c_drdy_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

  assign c_drdy = c_drdy_q;
  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;

endmodule

// File: tb/tb_sd_mirror_buf.sv
// Self-checking bench for sd_mirror_buf: directed scenarios plus a random soak, checked
// against a queue-of-entries model and per-receiver delivery scoreboards.
module tb_sd_mirror_buf;

  localparam int MC = 3;
  localparam int W  = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_srdy;
  logic          c_drdy;
  logic [W-1:0]  c_data;
  logic [MC-1:0] c_dst_vld;
  logic [MC-1:0] p_srdy;
  logic [MC-1:0] p_drdy;
  logic [W-1:0]  p_data;

  sd_mirror_buf #(.mirror_cnt(MC), .width(W), .depth(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_srdy    (c_srdy),
    .c_drdy    (c_drdy),
    .c_data    (c_data),
    .c_dst_vld (c_dst_vld),
    .p_srdy    (p_srdy),
    .p_drdy    (p_drdy),
    .p_data    (p_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [MC-1:0] pend;
  } ent_t;

  ent_t         mq [$];
  logic [W-1:0] sb [MC][$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model and the DUT.
  task automatic cycle(input logic srdy, input logic [W-1:0] data,
                       input logic [MC-1:0] dst, input logic [MC-1:0] drdy);
    logic [MC-1:0] ms;
    logic [MC-1:0] xf;
    logic [MC-1:0] pend;
    logic          acc;
    ent_t          h;
    ms = (mq.size() != 0) ? mq[0].pend : '0;
    chk("c_drdy", {31'd0, c_drdy}, {31'd0, (mq.size() < D)});
    chk("p_srdy", {29'd0, p_srdy}, {29'd0, ms});
    if (mq.size() != 0) chk("p_data", p_data, mq[0].data);
    c_srdy    = srdy;
    c_data    = data;
    c_dst_vld = dst;
    p_drdy    = drdy;
    xf = ms & drdy;
    for (int i = 0; i < MC; i++) begin
      if (xf[i]) begin
        chk($sformatf("rx%0d_expected", i), {31'd0, xf[i]}, {31'd0, (sb[i].size() != 0)});
        if (sb[i].size() != 0) chk($sformatf("rx%0d_data", i), p_data, sb[i].pop_front());
      end
    end
    acc = srdy && (mq.size() < D);
    if (mq.size() != 0) begin
      h = mq[0];
      h.pend = h.pend & ~xf;
      if (h.pend == '0) void'(mq.pop_front());
      else mq[0] = h;
    end
    if (acc) begin
      pend = (dst == '0) ? '1 : dst;
      h.data = data;
      h.pend = pend;
      mq.push_back(h);
      for (int i = 0; i < MC; i++) if (pend[i]) sb[i].push_back(data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    c_srdy    = 1'b1;
    c_data    = 32'hDEAD_BEEF;
    c_dst_vld = 3'b111;
    p_drdy    = 3'b111;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    for (int i = 0; i < MC; i++) sb[i].delete();
    chk("rst_c_drdy", {31'd0, c_drdy}, 32'd1);
    chk("rst_p_srdy", {29'd0, p_srdy}, 32'd0);
    chk("rst_p_data", p_data, 32'd0);
    reset  = 1'b0;
    c_srdy = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    c_srdy    = 1'b0;
    c_data    = '0;
    c_dst_vld = '0;
    p_drdy    = '0;
    @(negedge clk);
    do_reset();

    // broadcast stream
    cycle(1'b1, 32'h11, 3'b000, 3'b111);
    chk("bc_first_srdy", {29'd0, p_srdy}, 32'h7);
    chk("bc_first_data", p_data, 32'h11);
    cycle(1'b1, 32'h22, 3'b000, 3'b111);
    chk("bc_second_data", p_data, 32'h22);
    cycle(1'b1, 32'h33, 3'b000, 3'b111);
    chk("bc_third_data", p_data, 32'h33);
    chk("bc_c_drdy", {31'd0, c_drdy}, 32'd1);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);
    chk("bc_drained", {29'd0, p_srdy}, 32'd0);

    // staggered accept
    cycle(1'b1, 32'hAA, 3'b111, 3'b000);
    chk("stag_0", {29'd0, p_srdy}, 32'h7);
    cycle(1'b0, 32'h0, 3'b000, 3'b001);
    chk("stag_1", {29'd0, p_srdy}, 32'h6);
    cycle(1'b0, 32'h0, 3'b000, 3'b100);
    chk("stag_2", {29'd0, p_srdy}, 32'h2);
    chk("stag_2_data", p_data, 32'hAA);
    cycle(1'b0, 32'h0, 3'b000, 3'b010);
    chk("stag_3", {29'd0, p_srdy}, 32'h0);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);

    // masked routing
    cycle(1'b1, 32'h01, 3'b010, 3'b111);
    chk("mask_a_srdy", {29'd0, p_srdy}, 32'h2);
    cycle(1'b1, 32'h02, 3'b101, 3'b111);
    chk("mask_b_srdy", {29'd0, p_srdy}, 32'h5);
    chk("mask_b_data", p_data, 32'h02);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);
    chk("mask_done", {29'd0, p_srdy}, 32'h0);

    // full and backpressure
    cycle(1'b1, 32'hA1, 3'b000, 3'b000);
    cycle(1'b1, 32'hA2, 3'b000, 3'b000);
    chk("full_drdy", {31'd0, c_drdy}, 32'd0);
    cycle(1'b1, 32'hA3, 3'b000, 3'b000);
    chk("full_hold", {31'd0, c_drdy}, 32'd0);
    chk("full_head", p_data, 32'hA1);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);
    chk("full_free", {31'd0, c_drdy}, 32'd1);
    chk("full_next", p_data, 32'hA2);
    cycle(1'b1, 32'hA3, 3'b000, 3'b111);
    chk("full_third", p_data, 32'hA3);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);

    // reset mid-operation
    cycle(1'b1, 32'hB1, 3'b000, 3'b000);
    cycle(1'b1, 32'hB2, 3'b000, 3'b001);
    do_reset();
    cycle(1'b1, 32'hC1, 3'b011, 3'b000);
    chk("post_rst_srdy", {29'd0, p_srdy}, 32'h3);
    chk("post_rst_data", p_data, 32'hC1);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);
    cycle(1'b0, 32'h0, 3'b000, 3'b111);

    // random soak
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom(),
            ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom()), 3'($urandom()));
    end

    // drain with all receivers ready, then nothing may remain owed
    for (int n = 0; n < 4 * D; n++) cycle(1'b0, 32'h0, 3'b000, 3'b111);
    for (int i = 0; i < MC; i++) chk($sformatf("rx%0d_left", i), sb[i].size(), 32'd0);
    chk("model_left", mq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
